// File: rtl/maxpool_stream_ctrl.sv
// maxpool_stream_ctrl: streaming 1x2 signed max-pool over channel-major frames with start/done control
module maxpool_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int InputW     = 256,
    parameter int Depth      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam int Pairs = InputW / 2;
    localparam int PW    = (Pairs > 1) ? $clog2(Pairs) : 1;
    localparam int CW    = (Depth > 1) ? $clog2(Depth) : 1;
    typedef enum logic [2:0] {IDLE, FIRST, SECOND, OUT, DONE} state_t;
    state_t                r_state;
    logic [PW-1:0]         r_pair_cnt;
    logic [CW-1:0]         r_ch_cnt;
    logic [DATA_WIDTH-1:0] r_a;
    logic                  w_pair_end;
    logic                  w_ch_end;
    assign w_pair_end = r_pair_cnt == PW'(Pairs - 1);
    assign w_ch_end   = r_ch_cnt == CW'(Depth - 1);
    assign in_ready   = (r_state == FIRST) || (r_state == SECOND);
    assign busy       = r_state != IDLE;
    assign done       = r_state == DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pair_cnt <= '0;
            r_ch_cnt   <= '0;
            r_a        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_pair_cnt <= '0;
                    r_ch_cnt   <= '0;
                    r_state    <= FIRST;
                end
                FIRST: if (in_valid) begin
                    r_a     <= in_data;
                    r_state <= SECOND;
                end
                SECOND: if (in_valid) begin
                    // ties keep the first sample of the pair
                    out_data  <= ($signed(in_data) > $signed(r_a)) ? in_data : r_a;
                    out_valid <= 1'b1;
                    out_last  <= w_pair_end && w_ch_end;
                    r_state   <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (w_pair_end && w_ch_end) begin
                        r_state <= DONE;
                    end else begin
                        r_state    <= FIRST;
                        r_pair_cnt <= w_pair_end ? '0 : r_pair_cnt + PW'(1);
                        r_ch_cnt   <= w_pair_end ? r_ch_cnt + CW'(1) : r_ch_cnt;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// tb_maxpool_stream_ctrl: table, directed and randomized checks of the pairwise max-pool stream controller
module tb_maxpool_stream_ctrl;
    localparam int W = 16;
    typedef logic [W-1:0] frame_t [8];
    typedef struct { logic [W-1:0] d; logic l; } exp_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] m; } vec_t;
    logic clk = 0, reset = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid, out_last, busy, done;
    logic [W-1:0] out_data;
    int checks = 0, errors = 0, done_cnt = 0, frames = 0, cyc = 0, start_cyc = 0, done_cyc = 0, rmode = 1;
    exp_t q[$];
    exp_t me;
    logic pv = 0, pr = 0, pl = 0, prst = 1;
    logic [W-1:0] pd = '0;

    maxpool_stream_ctrl #(.DATA_WIDTH(W), .InputW(4), .Depth(2)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1 out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        end
    endtask

    function automatic logic [W-1:0] pmax(input logic [W-1:0] a, input logic [W-1:0] b);
        return (int'($signed(b)) > int'($signed(a))) ? b : a;
    endfunction

    always @(negedge clk) begin
        if (pv && !pr && !prst) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, pd);
            chk("hold_last", out_last, pl);
        end
        if (!out_valid) chk("last_without_valid", out_last, 0);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %0h with no output due", out_data);
            end else begin
                me = q.pop_front();
                chk("out_data", out_data, me.d);
                chk("out_last", out_last, me.l);
            end
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; prst = reset;
    end

    task automatic start_frame();
        int n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        start = 1;
        @(negedge clk);
        start = 0;
        start_cyc = cyc;
        frames++;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic send(input logic [W-1:0] x, input int gap);
        int n = 0;
        repeat (gap) begin in_valid = 0; @(negedge clk); end
        in_data = x; in_valid = 1;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for sample %0h", x);
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_done(input bit poke);
        int n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        chk("done_seen", done, 1);
        if (poke) begin
            start = 1;
            @(negedge clk);
            start = 0;
            chk("start_in_done_ignored", busy, 0);
            @(negedge clk);
            chk("still_idle", busy, 0);
        end else @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic push_model(input frame_t s);
        for (int k = 0; k < 4; k++) q.push_back('{d: pmax(s[2*k], s[2*k+1]), l: (k == 3)});
    endtask

    task automatic run_frame(input frame_t s, input int maxgap, input bit poke);
        start_frame();
        push_model(s);
        for (int i = 0; i < 8; i++) send(s[i], $urandom_range(0, maxgap));
        wait_done(poke);
    endtask

    initial begin
        vec_t tab [8];
        frame_t s;
        logic [W-1:0] hd;
        int dc;
        tab = '{'{16'h0003, 16'hFFFB, 16'h0003}, '{16'h0007, 16'h0007, 16'h0007},
                '{16'hFFFF, 16'hFFFE, 16'hFFFF}, '{16'h7FFF, 16'h8000, 16'h7FFF},
                '{16'h8000, 16'h8000, 16'h8000}, '{16'hFFFF, 16'h0000, 16'h0000},
                '{16'h0001, 16'h0000, 16'h0001}, '{16'h8000, 16'h8001, 16'h8001}};
        repeat (2) @(negedge clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        // table frames, first one is the reference example at full rate
        for (int f = 0; f < 2; f++) begin
            start_frame();
            for (int k = 0; k < 4; k++) q.push_back('{d: tab[4*f+k].m, l: (k == 3)});
            for (int k = 0; k < 4; k++) begin
                send(tab[4*f+k].a, 0);
                send(tab[4*f+k].b, 0);
            end
            wait_done(f == 1);
            if (f == 0) chk("throughput_cycles_le_12", (done_cyc - start_cyc) <= 12, 1);
        end

        // downstream stall for 5 cycles with the next sample already offered
        s = '{16'h0010, 16'h0020, 16'hFF00, 16'h0001, 16'h1234, 16'h1233, 16'h8000, 16'h7FFF};
        rmode = 0;
        @(negedge clk);
        start_frame();
        push_model(s);
        send(s[0], 0);
        send(s[1], 0);
        chk("stall_valid", out_valid, 1);
        hd = out_data;
        in_data = s[2]; in_valid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid_hold", out_valid, 1);
            chk("stall_data_hold", out_data, hd);
            chk("stall_in_ready", in_ready, 0);
        end
        rmode = 1;
        @(negedge clk);
        chk("release_handshake", out_valid && out_ready, 1);
        @(negedge clk);
        chk("released_consumed", out_valid, 0);
        in_valid = 0;
        for (int i = 2; i < 8; i++) send(s[i], 0);
        wait_done(0);

        // in_valid toggling plus a start pulse while busy
        s = '{16'hFFF0, 16'hFFF1, 16'h0005, 16'hFFFF, 16'h4000, 16'hC000, 16'h0000, 16'h0000};
        start_frame();
        push_model(s);
        send(s[0], 1); send(s[1], 1);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 2; i < 8; i++) send(s[i], 1);
        wait_done(0);

        // mid-frame reset after 3 samples
        s = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
        start_frame();
        q.push_back('{d: pmax(s[0], s[1]), l: 1'b0});
        send(s[0], 0); send(s[1], 0); send(s[2], 0);
        dc = done_cnt;
        reset = 1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        reset = 0;
        frames--;
        chk("midrst_queue", q.size(), 0);
        q.delete();
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_cnt, dc);
        run_frame(s, 0, 0);

        // random streams with random backpressure
        rmode = 2;
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < 8; i++) s[i] = W'($urandom);
            if (f % 7 == 0) begin s[0] = 16'h8000; s[1] = 16'h7FFF; end
            run_frame(s, 2, (f % 10) == 3);
        end
        rmode = 1;
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt, frames);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
